// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler: paces enemy spawns into free slots round-robin and keeps the cumulative kill count
module enemy_spawn_scheduler #(
  parameter int N_SLOTS = 4,
  parameter int QUOTA = 2,
  parameter int SPAWN_GAP = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         stage,
  input  logic               changing_stage,
  input  logic               tick_en,
  input  logic [N_SLOTS-1:0] slot_alive,
  input  logic [N_SLOTS-1:0] kill_pulse,
  output logic [N_SLOTS-1:0] spawn,
  output logic [1:0]         spawn_type,
  output logic [3:0]         kills,
  output logic               quota_done
);
  localparam int PW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, READY, HOLD} state_t;
  state_t state, state_n;
  logic [7:0] gap_cnt, gap_n, issued, issued_n;
  logic [PW-1:0] rr_ptr, rr_n, grant_idx;
  logic [N_SLOTS-1:0] grant_oh;
  logic [4:0] kill_sum;
  logic [3:0] kills_n;
  logic play, found, grant, gap_hit, last;
  // first free slot at or above rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_SLOTS; k++)
      if (!found && !slot_alive[(int'(rr_ptr) + k) % N_SLOTS]) begin
        found = 1'b1;
        grant_idx = PW'((int'(rr_ptr) + k) % N_SLOTS);
      end
  end
  // next-state: non-play stage beats a stage change, which beats normal sequencing
  always_comb begin
    state_n = state;
    if (!play) state_n = IDLE;
    else if (changing_stage || state == IDLE) state_n = WAIT;
    else if (state == WAIT && gap_hit) state_n = READY;
    else if (grant) state_n = last ? HOLD : WAIT;
  end
  // datapath next values: gap pacing, quota count, arbiter pointer, kill accumulation
  always_comb begin
    play = stage >= 4'd1 && stage <= 4'd4;
    gap_hit = tick_en && gap_cnt == 8'(SPAWN_GAP - 1);
    grant = play && !changing_stage && state == READY && found;
    last = issued + 8'd1 == 8'(QUOTA);
    gap_n = (!play || changing_stage) ? 8'd0 : (state == WAIT && tick_en) ? (gap_hit ? 8'd0 : gap_cnt + 8'd1) : gap_cnt;
    issued_n = (!play || changing_stage) ? 8'd0 : grant ? issued + 8'd1 : issued;
    rr_n = grant ? (grant_idx == PW'(N_SLOTS - 1) ? '0 : grant_idx + 1'b1) : rr_ptr;
    grant_oh = grant ? {{(N_SLOTS-1){1'b0}}, 1'b1} << grant_idx : '0;
    kill_sum = {1'b0, kills} + 5'($countones(kill_pulse));
    kills_n = play ? (kill_sum > 5'd15 ? 4'd15 : kill_sum[3:0]) : stage == 4'd0 ? 4'd0 : kills;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gap_cnt <= '0;
      issued <= '0;
      rr_ptr <= '0;
      spawn <= '0;
      spawn_type <= '0;
      kills <= '0;
      quota_done <= 1'b0;
    end else begin
      state <= state_n;
      gap_cnt <= gap_n;
      issued <= issued_n;
      rr_ptr <= rr_n;
      spawn <= grant_oh;
      spawn_type <= grant ? stage[1:0] - 2'd1 : spawn_type;
      kills <= kills_n;
      quota_done <= state_n == HOLD;
    end
  end
endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// tb_enemy_spawn_scheduler: randomized scoreboard bench against a countdown/phase reference model
module tb_enemy_spawn_scheduler;
  localparam int N = 4;
  localparam int QUOTA = 2;
  localparam int GAP = 4;
  logic clk = 0, rst = 1, changing_stage = 0, tick_en = 0;
  logic [3:0] stage = 0;
  logic [N-1:0] slot_alive = 0, kill_pulse = 0;
  logic [N-1:0] spawn;
  logic [1:0] spawn_type;
  logic [3:0] kills;
  logic quota_done;
  int compared = 0, mismatched = 0;
  bit started = 0;
  int m_phase, m_left, m_issued, m_ptr, m_kills;
  bit m_qd;
  logic [5:0] exp_q[$];

  enemy_spawn_scheduler #(.N_SLOTS(N), .QUOTA(QUOTA), .SPAWN_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .stage(stage), .changing_stage(changing_stage), .tick_en(tick_en),
    .slot_alive(slot_alive), .kill_pulse(kill_pulse), .spawn(spawn), .spawn_type(spawn_type),
    .kills(kills), .quota_done(quota_done));

  always #5 clk = ~clk;

  // phases: 0 idle, 1 counting down ticks, 2 looking for a free slot, 3 quota reached
  task automatic model_step();
    bit play;
    if (rst) begin
      m_phase = 0; m_left = GAP; m_issued = 0; m_ptr = 0; m_kills = 0; m_qd = 0;
      return;
    end
    play = stage >= 1 && stage <= 4;
    if (play) m_kills = (m_kills + $countones(kill_pulse) > 15) ? 15 : m_kills + $countones(kill_pulse);
    else if (stage == 0) m_kills = 0;
    if (!play) begin
      m_phase = 0; m_issued = 0; m_left = GAP;
    end else if (changing_stage || m_phase == 0) begin
      if (changing_stage) m_issued = 0;
      m_phase = 1; m_left = GAP;
    end else if (m_phase == 1) begin
      if (tick_en) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_ptr + k) % N;
        if (!slot_alive[s]) begin
          exp_q.push_back({4'(1 << s), 2'(stage - 1)});
          m_issued++;
          m_ptr = (s + 1) % N;
          m_phase = (m_issued == QUOTA) ? 3 : 1;
          m_left = GAP;
          break;
        end
      end
    end
    m_qd = m_phase == 3;
  endtask

  task automatic drive(input logic r, input logic [3:0] st, input logic ch, input logic tk,
                       input logic [N-1:0] al, input logic [N-1:0] kp);
    @(negedge clk);
    rst = r; stage = st; changing_stage = ch; tick_en = tk; slot_alive = al; kill_pulse = kp;
    model_step();
  endtask

  always @(posedge clk) if (started) begin
    #1;
    compared += 2;
    if (kills !== 4'(m_kills)) begin
      mismatched++;
      $display("FAIL kills t=%0t got %0d want %0d", $time, kills, m_kills);
    end
    if (quota_done !== m_qd) begin
      mismatched++;
      $display("FAIL quota_done t=%0t got %0b want %0b", $time, quota_done, m_qd);
    end
    if (rst) begin
      compared++;
      if (spawn_type !== 2'd0) begin
        mismatched++;
        $display("FAIL reset_spawn_type t=%0t got %0d want 0", $time, spawn_type);
      end
    end
    if (spawn !== 0) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_spawn t=%0t got %b/%0d want none", $time, spawn, spawn_type);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({spawn, spawn_type} !== e) begin
          mismatched++;
          $display("FAIL spawn t=%0t got %b/%0d want %b/%0d", $time, spawn, spawn_type, e[5:2], e[1:0]);
        end
      end
    end else if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL missed_spawn t=%0t got 0000 want %b/%0d", $time, exp_q[0][5:2], exp_q[0][1:0]);
      exp_q.delete();
    end
  end

  initial begin
    logic [3:0] st, pick;
    logic ch;
    model_step();
    started = 1;
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0);
    repeat (20) drive(0, 1, 0, 1, 0, 0);
    drive(0, 2, 1, 1, 4'hF, 0);
    repeat (30) drive(0, 2, 0, 1, 4'hF, 0);
    repeat (3) drive(0, 2, 0, 1, 4'b1011, 0);
    repeat (12) drive(0, 2, 0, 1, 4'b0000, 0);
    drive(0, 2, 0, 0, 0, 4'b0111);
    drive(0, 2, 0, 0, 0, 4'b1011);
    repeat (4) drive(0, 2, 0, 0, 0, 4'b1111);
    drive(0, 3, 1, 1, 0, 0);
    repeat (2) drive(0, 3, 0, 1, 0, 4'b0001);
    drive(0, 4'hF, 1, 1, 0, 4'b1111);
    repeat (10) drive(0, 4'hF, 0, 1, 0, 4'b0101);
    drive(0, 0, 1, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 1, 1, 4'hF, 0);
    repeat (10) drive(0, 1, 0, 1, 4'hF, 0);
    drive(1, 1, 0, 1, 0, 0);
    repeat (3) drive(0, 1, 0, 1, 4'hF, 0);
    st = 1; ch = 0;
    for (int i = 0; i < 4000; i++) begin
      logic chg_now;
      chg_now = ch;
      ch = 0;
      if ($urandom_range(99) < 3) begin
        pick = 4'($urandom_range(7));
        st = pick == 6 ? 4'hE : pick == 7 ? 4'hF : pick;
        ch = 1;
      end
      drive($urandom_range(399) == 0, st, chg_now, $urandom_range(2) == 0,
            4'($urandom), $urandom_range(5) == 0 ? 4'($urandom) : 4'd0);
    end
    repeat (4) drive(0, 0, 0, 0, 0, 0);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/enemy_spawn_scheduler.md
Name: enemy_spawn_scheduler

Overview:
- Sequences enemy spawning for the active play stages (1..4).
- Shares N enemy slots with a round-robin arbiter.
- Accumulates the cumulative kill count that the stage controller consumes.
- Sits between the stage controller (stage, changing_stage) and the per-slot enemy FSMs (slot_alive, kill_pulse).

Parameters:
- N_SLOTS, 4: number of enemy slots (2..8).
- QUOTA, 2: enemies spawned per stage.
- SPAWN_GAP, 50: tick_en pulses between consecutive spawns (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- stage  in  4  current stage: 0 = title; 1..4 = play; e = win; f = gameover
- changing_stage  in  1  one-cycle pulse on the cycle after any stage transition
- tick_en  in  1  one-cycle frame/timer tick; gates spawn-gap counting
- slot_alive  in  N_SLOTS  per-slot occupied flag
- kill_pulse  in  N_SLOTS  per-slot one-cycle enemy-destroyed pulse
- spawn  out  N_SLOTS  one-hot, one-cycle spawn command to the chosen slot
- spawn_type  out  2  enemy type, valid with spawn: stage-1
- kills  out  4  cumulative kills, saturating at 15
- quota_done  out  1  all QUOTA enemies of the current stage have been issued

Behaviour:
- Reset values:
  - spawn = 0, spawn_type = 0, kills = 0, quota_done = 0.
  - FSM = IDLE, gap_cnt = 0, issued = 0, rr_ptr = 0.
- All outputs are registered.
- FSM states:
  - IDLE: no spawning.
    - Go to WAIT when stage is in 1..4 and changing_stage = 1.
    - Also go to WAIT when stage is in 1..4 and the FSM is still in IDLE, which covers a missed pulse.
  - WAIT:
    - On each tick_en, gap_cnt increments.
    - When gap_cnt reaches SPAWN_GAP-1 together with a tick_en, clear gap_cnt and go to READY.
  - READY:
    - Any slot with slot_alive = 0 → grant the first free slot found searching upward from rr_ptr, wrapping modulo N_SLOTS.
    - On grant: spawn = one-hot of that slot for exactly one cycle; spawn_type = stage[1:0]-1; issued++; rr_ptr = granted index + 1, wrapping.
    - After grant: if issued == QUOTA, go to HOLD; otherwise go to WAIT.
    - No free slot → stay in READY with spawn = 0 and no timeout. The grant happens on the first cycle a slot frees.
  - HOLD: quota_done = 1; no spawns. Leave only via changing_stage or a non-play stage.
- Global overrides, highest priority first:
  - rst.
  - stage not in 1..4 → IDLE; issued and gap_cnt are cleared.
  - changing_stage = 1 while in a play stage → WAIT; issued = 0, gap_cnt = 0, quota_done = 0. This applies from any state. A spawn scheduled that same cycle is suppressed.
- Kill counter:
  - kills += popcount(kill_pulse) each cycle while stage is in 1..4, saturating at 15. Simultaneous pulses all count.
  - kills holds its value in stages e and f (frozen for display).
  - kills clears to 0 while stage == 0.
  - kills is not cleared on stage transitions between 1..4: it is cumulative, with thresholds 2/4/6/8 at defaults.
- kill_pulse is ignored outside stages 1..4.
- Latency:
  - spawn is asserted on the cycle after READY sees a free slot.
  - kills updates on the cycle after kill_pulse.
- A spawn and a kill on the same slot in the same cycle are both honoured: the kill is counted and the slot is re-filled.
- Stage values 5..d are treated as non-play: IDLE, kills held.

Test Plan:
- Reset, then stage = 1 with a changing_stage pulse and tick_en every cycle, SPAWN_GAP = 4, all slots free → spawn = 0001 4 ticks later, spawn = 0010 4 ticks after that; quota_done = 1 after the second spawn; spawn_type = 0.
- All slots alive in READY for 20 cycles → no spawn. Drop slot_alive[2] → spawn = 0100 on the next cycle. rr_ptr then points to slot 3.
- kill_pulse = 1011 in a single cycle during stage 2 with kills = 3 → kills = 6 next cycle. Repeated pulses from kills = 14 → saturates at 15.
- Stage 1 → 2 with changing_stage while in HOLD → quota_done drops, issued = 0, two more spawns with spawn_type = 1. kills is not cleared.
- Stage → f mid-WAIT → no further spawns, kills frozen. Stage → 0 → kills = 0.
- Assert rst while in READY with a free slot → spawn stays 0, all outputs return to reset values the next cycle.
